// File: rtl/m68040_bus_ctrl.sv
// m68040_bus_ctrl -- 68040-style bus transfer controller.
//
// Decodes the CPU address at transfer start into one of NREG regions (by
// a[31:28]), inserts per-region wait states gated by the region's device-ready
// line, and answers with TA (normal end), TEA (decode miss or timeout) and TBI
// (line transfer to a region that cannot burst). Line transfers to
// burst-capable regions run four beats.
//
// Ports:
//   clk      sole clock, rising edge
//   rst      asynchronous reset, active low
//   ts_n     transfer start (sampled only in IDLE), active low
//   a        CPU address
//   rw       1 = read (latched with the transfer; sequencing is direction-independent)
//   siz      transfer size, 2'b11 = line
//   dev_rdy  per-region device ready, active high
//   ta_n     transfer acknowledge, active low (registered)
//   tea_n    transfer error acknowledge, active low (registered)
//   tbi_n    burst inhibit, active low (registered)
//   sel      one-hot region select (registered)
//   beat     current line-transfer beat index (registered)
//   addr_q   address latched at transfer start
//   busy     high whenever the controller is not IDLE (registered)
module m68040_bus_ctrl #(
  parameter int                     NREG      = 4,
  parameter int                     WS_W      = 4,
  parameter logic [4*NREG-1:0]      REG_NIB   = {4'h8, 4'h3, 4'h2, 4'h0},
  parameter logic [WS_W*NREG-1:0]   REG_WS    = {4'd0, 4'd5, 4'd5, 4'd2},
  parameter logic [NREG-1:0]        REG_BURST = 4'b0001,
  parameter int                     TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ts_n,
  input  logic [31:0]     a,
  input  logic            rw,
  input  logic [1:0]      siz,
  input  logic [NREG-1:0] dev_rdy,
  output logic            ta_n,
  output logic            tea_n,
  output logic            tbi_n,
  output logic [NREG-1:0] sel,
  output logic [1:0]      beat,
  output logic [31:0]     addr_q,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t          state_reg, state_next;
  logic [2:0]      idx_reg, idx_next;
  logic [WS_W-1:0] wait_reg, wait_next;
  logic [7:0]      to_reg, to_next;
  logic [1:0]      beat_next;
  logic [31:0]     addr_next;
  logic [1:0]      siz_reg, siz_next;
  logic            rw_reg, rw_next;
  logic            ta_next, tea_next, tbi_next, busy_next;
  logic [NREG-1:0] sel_next;

  // Direction is captured for completeness; nothing downstream depends on it.
  logic unused_attr;
  assign unused_attr = rw_reg;

  // Region match vector from the live address (only used in IDLE).
  logic [NREG-1:0] match;
  logic [WS_W-1:0] ws_arr [NREG];
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_region
      assign match[gi]  = (a[31:28] == REG_NIB[4*gi +: 4]);
      assign ws_arr[gi] = REG_WS[WS_W*gi +: WS_W];
    end
  endgenerate

  // Lowest matching index wins: scan downwards so the last hit is the lowest.
  logic       hit;
  logic [2:0] hit_idx;
  always_comb begin
    hit     = |match;
    hit_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = 3'(i);
    end
  end

  // Attributes of the region owning the current transfer.
  logic [WS_W-1:0] cur_ws;
  logic            cur_rdy;
  logic            cur_burst;
  always_comb begin
    cur_ws    = '0;
    cur_rdy   = 1'b0;
    cur_burst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (idx_reg == 3'(i)) begin
        cur_ws    = ws_arr[i];
        cur_rdy   = dev_rdy[i];
        cur_burst = REG_BURST[i];
      end
    end
  end

  logic line_xfer;
  assign line_xfer = (siz_reg == 2'b11);

  // Next-state and next-output logic.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    wait_next  = wait_reg;
    to_next    = to_reg;
    beat_next  = beat;
    addr_next  = addr_q;
    siz_next   = siz_reg;
    rw_next    = rw_reg;

    case (state_reg)
      IDLE: begin
        if (!ts_n) begin
          addr_next = a;
          siz_next  = siz;
          rw_next   = rw;
          wait_next = '0;
          to_next   = '0;
          beat_next = 2'd0;
          if (hit) begin
            idx_next   = hit_idx;
            state_next = WAIT;
          end else begin
            state_next = ERR;
          end
        end
      end
      WAIT: begin
        if ((wait_reg >= cur_ws) && cur_rdy) begin
          state_next = ACK;
        end else if (to_reg == TO_LAST) begin
          state_next = ERR;
        end else begin
          to_next = to_reg + 8'd1;
        end
        // Saturate so long waits on a slow device cannot wrap the count.
        if (wait_reg != '1) wait_next = wait_reg + WS_W'(1);
      end
      ACK: begin
        if (line_xfer && cur_burst && (beat != 2'd3)) begin
          // The ACK cycle itself is count 0 of the next beat, so the
          // following WAIT cycle starts at 1.
          state_next = WAIT;
          beat_next  = beat + 2'd1;
          wait_next  = WS_W'(1);
          to_next    = '0;
        end else begin
          state_next = IDLE;
          beat_next  = 2'd0;
        end
      end
      ERR: begin
        state_next = IDLE;
        beat_next  = 2'd0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they line
    // up with the state register and have no input-to-output path.
    ta_next   = (state_next != ACK);
    tea_next  = (state_next != ERR);
    tbi_next  = !((state_next == ACK) && line_xfer && !cur_burst);
    busy_next = (state_next != IDLE);
    sel_next  = '0;
    for (int i = 0; i < NREG; i++) begin
      sel_next[i] = ((state_next == WAIT) || (state_next == ACK)) && (idx_next == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      wait_reg  <= '0;
      to_reg    <= '0;
      siz_reg   <= '0;
      rw_reg    <= 1'b0;
      beat      <= 2'd0;
      addr_q    <= '0;
      ta_n      <= 1'b1;
      tea_n     <= 1'b1;
      tbi_n     <= 1'b1;
      busy      <= 1'b0;
      sel       <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      wait_reg  <= wait_next;
      to_reg    <= to_next;
      siz_reg   <= siz_next;
      rw_reg    <= rw_next;
      beat      <= beat_next;
      addr_q    <= addr_next;
      ta_n      <= ta_next;
      tea_n     <= tea_next;
      tbi_n     <= tbi_next;
      busy      <= busy_next;
      sel       <= sel_next;
    end
  end

endmodule
